// File: rtl/rabb_pkg.sv
// Shared constants and types for the Ray-AABB (FP 11/9) slab-test datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rabb_pkg;

   // Field positions in the 23-bit FP word used by the comparator bank
   localparam int FP_W   = 23;
   localparam int EXC_HI = 22;
   localparam int EXC_LO = 21;
   localparam int SIGN   = 20;

   // Default comparator-bank latency and ray tag width
   localparam int CMP_LAT_DEF = 4;
   localparam int TAG_W_DEF   = 8;

   // One collected result: did the ray hit the box, and which ray it was
   typedef struct packed {
      logic                 hit;
      logic [TAG_W_DEF-1:0] tag;
   } hit_entry_t;

endpackage

// File: rtl/ray_slab_hit_collector_if.sv
// Handshake bundle between the ray issuer/comparator bank and the hit collector.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles issue, out_ready drains the result queue.
interface ray_slab_hit_collector_if #(
   parameter int TAG_W   = 8,
   parameter int NUM_CMP = 4,
   parameter int CNT_W   = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [TAG_W-1:0]   in_tag;
   logic [NUM_CMP-1:0] le_flags;
   logic               out_valid;
   logic               out_ready;
   logic               out_hit;
   logic [TAG_W-1:0]   out_tag;
   logic [CNT_W-1:0]   hit_count;

   // Issuer / consumer side
   modport master (
      output in_valid, in_tag, le_flags, out_ready,
      input  in_ready, out_valid, out_hit, out_tag, hit_count
   );

   // Collector side
   modport slave (
      input  in_valid, in_tag, le_flags, out_ready,
      output in_ready, out_valid, out_hit, out_tag, hit_count
   );
endinterface

// File: rtl/rabb_sync_fifo.sv
// Generic synchronous FIFO with separate occupancy count and registered head storage.
// Latency: a pushed entry is visible at head_o the cycle after the push.
// Backpressure: none internally; caller must not push when full unless popping.
module rabb_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_dat_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             full, do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && (cnt_q != '0);
   // A push into a full FIFO is only legal when the head leaves the same cycle
   assign do_push = push_i && (!full || do_pop);
   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   // Next-state for pointers (wrap naturally, DEPTH is a power of two) and count
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage and pointer registers; storage cleared so the head reads zero after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (do_push) mem_q[wr_q] <= push_dat_i;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full && !do_pop));

endmodule

// File: rtl/ray_slab_hit_collector.sv
// Tracks issued ray tags through a fixed delay matching the comparators, ANDs slab flags into a hit bit, queues {hit, tag}.
// Latency: issue at t -> out_valid at t+CMP_LAT+1 when the queue was empty.
// Backpressure: in_ready is a credit check (queued + in flight < FIFO_DEPTH), so no result is ever dropped.
module ray_slab_hit_collector
   import rabb_pkg::*;
#(
   parameter int CMP_LAT    = CMP_LAT_DEF,
   parameter int NUM_CMP    = 4,
   parameter int TAG_W      = TAG_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input logic                       clk,
   input logic                       rst,
   ray_slab_hit_collector_if.slave   bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic             hit;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic [CMP_LAT-1:0] v_q;
   logic [TAG_W-1:0]   tag_q [CMP_LAT];
   logic               issue, push, pop;
   entry_t             push_dat, head;
   logic [CW-1:0]      fifo_cnt;
   logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;

   assign issue = bus.in_valid & bus.in_ready;

   // Delay line: shifts every cycle, never stalls, so it always lines up with le_flags
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         for (int i = 0; i < CMP_LAT; i++) tag_q[i] <= '0;
      end else begin
         v_q[0]   <= issue;
         tag_q[0] <= bus.in_tag;
         for (int i = 1; i < CMP_LAT; i++) begin
            v_q[i]   <= v_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Flags are only meaningful when a tracked ray is at the exit stage
   assign push         = v_q[CMP_LAT-1];
   assign push_dat.hit = &bus.le_flags;
   assign push_dat.tag = tag_q[CMP_LAT-1];

   // Credit: every in-flight ray has a reserved FIFO slot
   assign bus.in_ready  = (int'(fifo_cnt) + $countones(v_q)) < FIFO_DEPTH;
   assign bus.out_valid = (fifo_cnt != '0);
   assign pop           = bus.out_valid & bus.out_ready;
   assign bus.out_hit   = head.hit;
   assign bus.out_tag   = head.tag;
   assign bus.hit_count = hit_cnt_q;

   rabb_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .head_o     (head),
      .count_o    (fifo_cnt)
   );

   // Saturating count of hits handed to the consumer
   always_comb begin
      hit_cnt_d = hit_cnt_q;
      if (pop && head.hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
   end

   // Hit counter register
   always_ff @(posedge clk) begin
      if (rst) hit_cnt_q <= '0;
      else     hit_cnt_q <= hit_cnt_d;
   end

endmodule

// File: tb/tb_ray_slab_hit_collector.sv
// Bench for ray_slab_hit_collector: two instances (default, and deep FIFO with 2-bit counter).
// Latency: model tracks issue timestamps; flags are driven exactly CMP_LAT edges after issue.
// Backpressure: out_ready and in_valid are driven per instance by directed tests.
module tb_ray_slab_hit_collector;
   import rabb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ray_slab_hit_collector_if #(.TAG_W(8), .NUM_CMP(4), .CNT_W(16)) bus_a ();
   ray_slab_hit_collector_if #(.TAG_W(8), .NUM_CMP(4), .CNT_W(2))  bus_b ();

   ray_slab_hit_collector #(.CMP_LAT(4), .NUM_CMP(4), .TAG_W(8), .FIFO_DEPTH(4), .CNT_W(16))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   ray_slab_hit_collector #(.CMP_LAT(4), .NUM_CMP(4), .TAG_W(8), .FIFO_DEPTH(8), .CNT_W(2))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   logic       iv [2];
   logic       ordy [2];
   logic [7:0] itag [2];
   logic [3:0] flg [2];
   logic [3:0] want [2];
   logic       irdy [2];
   logic       ov [2];
   logic       oh [2];
   logic [7:0] ot [2];
   logic [15:0] hc [2];

   assign bus_a.in_valid  = iv[0];
   assign bus_a.in_tag    = itag[0];
   assign bus_a.le_flags  = flg[0];
   assign bus_a.out_ready = ordy[0];
   assign bus_b.in_valid  = iv[1];
   assign bus_b.in_tag    = itag[1];
   assign bus_b.le_flags  = flg[1];
   assign bus_b.out_ready = ordy[1];
   assign irdy[0] = bus_a.in_ready;
   assign irdy[1] = bus_b.in_ready;
   assign ov[0]   = bus_a.out_valid;
   assign ov[1]   = bus_b.out_valid;
   assign oh[0]   = bus_a.out_hit;
   assign oh[1]   = bus_b.out_hit;
   assign ot[0]   = bus_a.out_tag;
   assign ot[1]   = bus_b.out_tag;
   assign hc[0]   = bus_a.hit_count;
   assign hc[1]   = {14'd0, bus_b.hit_count};

   typedef struct {
      logic [7:0] tag;
      logic [3:0] f;
      int         ex;
   } pend_t;

   pend_t      pq [2][$];
   hit_entry_t fq [2][$];
   int         hcm [2];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   function automatic int dep(input int k);
      return (k == 0) ? 4 : 8;
   endfunction

   function automatic int hmax(input int k);
      return (k == 0) ? 65535 : 3;
   endfunction

   function automatic bit model_rdy(input int k);
      return (fq[k].size() + pq[k].size()) < dep(k);
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0h expected %0h", nm, k, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Model: rays wait CMP_LAT edges after acceptance, then join an ordered result queue
   always @(posedge clk) begin
      bit mrdy;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            pq[k].delete();
            fq[k].delete();
            hcm[k] = 0;
         end else begin
            mrdy = model_rdy(k);
            if (ordy[k] && fq[k].size() != 0) begin
               if (fq[k][0].hit && hcm[k] < hmax(k)) hcm[k]++;
               void'(fq[k].pop_front());
            end
            if (pq[k].size() != 0 && pq[k][0].ex == cyc) begin
               fq[k].push_back('{hit: &flg[k], tag: pq[k][0].tag});
               void'(pq[k].pop_front());
            end
            if (iv[k] && mrdy) pq[k].push_back('{tag: itag[k], f: want[k], ex: cyc + 4});
         end
      end
   end

   // Comparator bank stand-in: real flags at a ray's exit edge, noise otherwise
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         if (pq[k].size() != 0 && pq[k][0].ex == cyc + 1) flg[k] = pq[k][0].f;
         else                                            flg[k] = 4'($urandom);
      end
   end

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int k = 0; k < 2; k++) begin
            chk("in_ready", k, 32'(irdy[k]), 32'(model_rdy(k)));
            chk("out_valid", k, 32'(ov[k]), 32'(fq[k].size() != 0));
            if (fq[k].size() != 0) begin
               chk("out_hit", k, 32'(oh[k]), 32'(fq[k][0].hit));
               chk("out_tag", k, 32'(ot[k]), 32'(fq[k][0].tag));
            end
            chk("hit_count", k, 32'(hc[k]), 32'(hcm[k]));
         end
      end
   end

   task automatic send_one(input int k, input logic [7:0] t, input logic [3:0] f);
      iv[k]   = 1'b1;
      itag[k] = t;
      want[k] = f;
      tick();
      iv[k]   = 1'b0;
   endtask

   // Offer n rays back-to-back, honouring in_ready; reports hits offered and cycles used
   task automatic stream(input int k, input int n, input bit rnd, output int g, output int used);
      g = 0;
      used = 0;
      for (int i = 0; i < n; i++) begin
         int w;
         iv[k]   = 1'b1;
         itag[k] = 8'(i + ((k == 0) ? 8'h40 : 8'h80));
         if (rnd) want[k] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
         else     want[k] = 4'hF;
         g += int'(&want[k]);
         w = 0;
         while (!irdy[k] && w < 100) begin
            tick();
            used++;
            w++;
         end
         if (w >= 100) chk("stream_timeout", k, 32'(w), 32'd0);
         tick();
         used++;
      end
      iv[k] = 1'b0;
   endtask

   initial begin
      int acc, ga, gb, ca, cb;
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1; itag[k] = '0; want[k] = '0; flg[k] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state on the first cycle after release
      for (int k = 0; k < 2; k++) begin
         chk("rst_in_ready", k, 32'(irdy[k]), 32'd1);
         chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
         chk("rst_hit_count", k, 32'(hc[k]), 32'd0);
         chk("rst_out_hit", k, 32'(oh[k]), 32'd0);
         chk("rst_out_tag", k, 32'(ot[k]), 32'd0);
      end

      // Single hit ray: visible exactly CMP_LAT+1 cycles after issue
      send_one(0, 8'h2A, 4'b1111);
      repeat (3) tick();
      chk("t2_not_yet", 0, 32'(ov[0]), 32'd0);
      tick();
      chk("t2_valid", 0, 32'(ov[0]), 32'd1);
      chk("t2_hit", 0, 32'(oh[0]), 32'd1);
      chk("t2_tag", 0, 32'(ot[0]), 32'h2A);
      tick();
      chk("t2_count", 0, 32'(hc[0]), 32'd1);
      chk("t2_empty", 0, 32'(ov[0]), 32'd0);

      // Miss ray
      send_one(0, 8'h05, 4'b1011);
      repeat (4) tick();
      chk("t3_valid", 0, 32'(ov[0]), 32'd1);
      chk("t3_hit", 0, 32'(oh[0]), 32'd0);
      chk("t3_tag", 0, 32'(ot[0]), 32'h05);
      tick();
      chk("t3_count", 0, 32'(hc[0]), 32'd1);

      // Backpressure: credit admits exactly FIFO_DEPTH rays
      ordy[0] = 1'b0;
      acc = 0;
      iv[0] = 1'b1;
      want[0] = 4'b0111;
      for (int i = 0; i < 8; i++) begin
         itag[0] = 8'(8'h10 + i);
         if (irdy[0]) acc++;
         tick();
      end
      iv[0] = 1'b0;
      repeat (6) tick();
      chk("t4_accepted", 0, 32'(acc), 32'd4);
      chk("t4_in_ready", 0, 32'(irdy[0]), 32'd0);
      chk("t4_head_tag", 0, 32'(ot[0]), 32'h10);
      ordy[0] = 1'b1;
      repeat (6) tick();
      chk("t4_drained", 0, 32'(ov[0]), 32'd0);
      chk("t4_ready_back", 0, 32'(irdy[0]), 32'd1);
      chk("t4_count", 0, 32'(hc[0]), 32'd1);

      // Streaming: A under credit limits, B at full rate
      fork
         stream(0, 64, 1'b1, ga, ca);
         stream(1, 64, 1'b1, gb, cb);
      join
      repeat (12) tick();
      chk("t5_golden_a", 0, 32'(hc[0]), 32'(1 + ga));
      chk("t5_rate_b", 1, 32'(cb), 32'd64);
      chk("t5_sat_b", 1, 32'(hc[1]), 32'((gb >= 3) ? 3 : gb));

      // Reset while rays are queued and in flight
      for (int k = 0; k < 2; k++) ordy[k] = 1'b0;
      for (int j = 0; j < 2; j++) begin
         for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b1; itag[k] = 8'(8'h60 + j); want[k] = 4'hF;
         end
         tick();
      end
      for (int k = 0; k < 2; k++) iv[k] = 1'b0;
      repeat (5) tick();
      for (int j = 0; j < 3; j++) begin
         for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b1; itag[k] = 8'(8'h70 + j); want[k] = 4'hF;
         end
         tick();
      end
      for (int k = 0; k < 2; k++) iv[k] = 1'b0;
      chk("t6_queued_b", 1, 32'(ov[1]), 32'd1);
      rst = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("t6_valid_cleared", k, 32'(ov[k]), 32'd0);
         chk("t6_ready", k, 32'(irdy[k]), 32'd1);
      end
      rst = 1'b0;
      for (int k = 0; k < 2; k++) ordy[k] = 1'b1;
      repeat (8) tick();
      for (int k = 0; k < 2; k++) begin
         chk("t6_no_stale", k, 32'(ov[k]), 32'd0);
         chk("t6_count", k, 32'(hc[k]), 32'd0);
      end

      // Counter saturation: five hits each
      fork
         stream(0, 5, 1'b0, ga, ca);
         stream(1, 5, 1'b0, gb, cb);
      join
      repeat (10) tick();
      chk("t7_count_a", 0, 32'(hc[0]), 32'd5);
      chk("t7_sat_b", 1, 32'(hc[1]), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
